// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and helpers for the decode-stage register hazard tracker.
// Latency classes name the result latency of each functional unit family.
package reg_scoreboard_pkg;

  localparam int DEF_MAX_LAT = 7;
  localparam int DEF_LAT_W   = 3;
  localparam int DEF_NUM_SRC = 2;

  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 2;
  localparam int LAT_MUL  = 4;

  // Out-of-range latencies are clamped rather than rejected.
  function automatic int sat_lat(input int lat, input int max_lat);
    return (lat > max_lat) ? max_lat : lat;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode-side bundle for the register scoreboard: issue request, operand
// sources, and the stall/accept/pending responses.
interface reg_scoreboard_if
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int LAT_W    = DEF_LAT_W,
  parameter int NUM_SRC  = DEF_NUM_SRC
);

  logic                      freeze;
  logic                      flush;
  logic                      issue_valid;
  logic                      issue_we;
  logic [ADDR_W-1:0]         issue_dst;
  logic [LAT_W-1:0]          issue_lat;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic                      stall;
  logic                      issue_fire;
  logic [NUM_REGS-1:0]       busy;
  logic [NUM_SRC*LAT_W-1:0]  src_wait;

  modport master (
    output freeze, flush, issue_valid, issue_we, issue_dst, issue_lat,
           src_valid, src_addr,
    input  stall, issue_fire, busy, src_wait
  );

  modport slave (
    input  freeze, flush, issue_valid, issue_we, issue_dst, issue_lat,
           src_valid, src_addr,
    output stall, issue_fire, busy, src_wait
  );

endinterface

// File: rtl/reg_scoreboard_cnt.sv
// One register's remaining-latency counter: load wins over the decrement,
// clear (reset or flush) wins over everything, dec_en low freezes it.
module scoreboard_cnt #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec_en,
  output logic [LAT_W-1:0] cnt,
  output logic             busy
);

  logic [LAT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (dec_en) begin
      if (load) begin
        r_cnt <= load_val;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - LAT_W'(1);
      end
    end
  end

  assign cnt  = r_cnt;
  assign busy = (r_cnt != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Register hazard tracker: per-register latency counters plus the source
// and WAW hazard compares that decide stall and issue acceptance.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_LAT  = DEF_MAX_LAT,
  parameter int LAT_W    = DEF_LAT_W,
  parameter int NUM_SRC  = DEF_NUM_SRC
) (
  input  logic              clk,
  input  logic              rst,
  reg_scoreboard_if.slave   sb
);

  localparam int ADDR_SPAN = 2 ** ADDR_W;

  // Counter view covering the full address space; unbacked entries read 0.
  logic [LAT_W-1:0]    w_cnt [ADDR_SPAN];
  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_SRC-1:0]  w_src_haz;
  logic [LAT_W-1:0]    w_lat_sat;
  logic                w_waw;
  logic                w_stall;
  logic                w_fire;
  logic                w_track;

  assign w_lat_sat = LAT_W'(sat_lat(int'(sb.issue_lat), MAX_LAT));
  assign w_track   = w_fire && sb.issue_we && (sb.issue_dst != '0) && (w_lat_sat != '0);

  genvar gi;
  generate
    for (gi = 0; gi < ADDR_SPAN; gi++) begin : g_reg
      if (gi == 0 || gi >= NUM_REGS) begin : g_zero
        assign w_cnt[gi] = '0;
        if (gi < NUM_REGS) begin : g_busy0
          assign w_busy[gi] = 1'b0;
        end
      end else begin : g_cnt
        scoreboard_cnt #(.LAT_W(LAT_W)) u_cnt (
          .clk      (clk),
          .rst      (rst),
          .clr      (sb.flush),
          .load     (w_track && (sb.issue_dst == ADDR_W'(gi))),
          .load_val (w_lat_sat),
          .dec_en   (~sb.freeze),
          .cnt      (w_cnt[gi]),
          .busy     (w_busy[gi])
        );
      end
    end

    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [ADDR_W-1:0] w_addr;
      assign w_addr = sb.src_addr[gi*ADDR_W +: ADDR_W];
      assign sb.src_wait[gi*LAT_W +: LAT_W] = sb.src_valid[gi] ? w_cnt[w_addr] : '0;
      assign w_src_haz[gi] = sb.src_valid[gi] && (w_cnt[w_addr] != '0);
    end
  endgenerate

  // A shorter-latency write may not overtake a pending longer one.
  assign w_waw   = sb.issue_we && (sb.issue_dst != '0) && (w_cnt[sb.issue_dst] > w_lat_sat);
  assign w_stall = sb.issue_valid && ((|w_src_haz) || w_waw);
  assign w_fire  = sb.issue_valid && !w_stall && !sb.freeze && !sb.flush;

  assign sb.stall      = w_stall;
  assign sb.issue_fire = w_fire;
  assign sb.busy       = w_busy;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench: the driver predicts each cycle's response from a
// ready-time model and queues it; the monitor compares on the falling edge.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int LW = 3;
  localparam int NS = 2;
  localparam int ML = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_scoreboard_if #(.NUM_REGS(NR), .ADDR_W(AW), .LAT_W(LW), .NUM_SRC(NS)) sb_if ();

  reg_scoreboard #(
    .NUM_REGS(NR), .ADDR_W(AW), .MAX_LAT(ML), .LAT_W(LW), .NUM_SRC(NS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  typedef struct {
    logic          stall;
    logic          fire;
    logic [NR-1:0] busy;
    logic [NS*LW-1:0] wait_v;
    int            dst;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   drive_rst = 1'b0;

  // Model: each register has an absolute "forwardable at" time measured in
  // unfrozen cycles; remaining latency is the distance to that time.
  longint act = 0;
  longint ready_at [NR];

  function automatic int remaining(input int r);
    if (r == 0) return 0;
    return (ready_at[r] > act) ? int'(ready_at[r] - act) : 0;
  endfunction

  task automatic chk(input string name, input longint unsigned got, input longint unsigned want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic step(input logic v, input logic we, input int dst, input int lat,
                      input logic [1:0] sv, input int a0, input int a1,
                      input logic frz, input logic fl);
    exp_t e;
    bit   haz;
    bit   waw;
    int   eff;
    rst                = drive_rst;
    sb_if.issue_valid  = v;
    sb_if.issue_we     = we;
    sb_if.issue_dst    = AW'(dst);
    sb_if.issue_lat    = LW'(lat);
    sb_if.src_valid    = sv;
    sb_if.src_addr     = {AW'(a1), AW'(a0)};
    sb_if.freeze       = frz;
    sb_if.flush        = fl;
    e.wait_v = '0;
    if (sv[0]) e.wait_v[LW-1:0]    = LW'(remaining(a0));
    if (sv[1]) e.wait_v[2*LW-1:LW] = LW'(remaining(a1));
    haz = (sv[0] && remaining(a0) != 0) || (sv[1] && remaining(a1) != 0);
    waw = we && (dst != 0) && (remaining(dst) > lat);
    e.stall = v && (haz || waw);
    e.fire  = v && !e.stall && !frz && !fl;
    for (int r = 0; r < NR; r++) e.busy[r] = (remaining(r) != 0);
    e.dst = dst;
    e.lat = lat;
    exp_q.push_back(e);
    @(posedge clk);
    if (fl || drive_rst) begin
      for (int r = 0; r < NR; r++) ready_at[r] = 0;
    end else if (!frz) begin
      act++;
      eff = (lat > ML) ? ML : lat;
      if (e.fire && we && dst != 0 && eff != 0) ready_at[dst] = act + eff;
    end
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  // Monitor: one queued expectation per cycle, checked away from the edge.
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        m = exp_q.pop_front();
        chk("stall",      longint'(sb_if.stall),      longint'(m.stall));
        chk("issue_fire", longint'(sb_if.issue_fire), longint'(m.fire));
        chk("busy",       longint'(sb_if.busy),       longint'(m.busy));
        chk("src_wait",   longint'(sb_if.src_wait),   longint'(m.wait_v));
        if (m.fire) $display("t=%0t issue accepted dst=$%0d lat=%0d", $time, m.dst, m.lat);
      end
    end
  end

  initial begin
    for (int r = 0; r < NR; r++) ready_at[r] = 0;
    rst = 1'b1;
    sb_if.issue_valid = 0; sb_if.issue_we = 0; sb_if.issue_dst = '0; sb_if.issue_lat = '0;
    sb_if.src_valid = '0; sb_if.src_addr = '0; sb_if.freeze = 0; sb_if.flush = 0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    idle(2);
    step(1, 0, 0, 0, 2'b01, 3, 0, 0, 0);              // no producer: fires at once
    // Load-use, then the same with lat 0.
    step(1, 1, 5, LAT_LOAD, 2'b00, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 2'b01, 5, 0, 0, 0);
    step(1, 1, 5, LAT_ALU, 2'b00, 0, 0, 0, 0);
    step(1, 0, 0, 0, 2'b01, 5, 0, 0, 0);
    // WAW behind a multiply.
    step(1, 1, 8, LAT_MUL, 2'b00, 0, 0, 0, 0);
    repeat (4) step(1, 1, 8, 1, 2'b00, 0, 0, 0, 0);
    idle(2);
    // Freeze stretches the busy window.
    step(1, 1, 2, 3, 2'b00, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    idle(4);
    // Flush mid-flight.
    step(1, 1, 9, 5, 2'b00, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    step(1, 0, 0, 0, 2'b10, 0, 9, 0, 0);
    // Register 0 is never tracked nor a hazard.
    step(1, 1, 0, 4, 2'b00, 0, 0, 0, 0);
    step(1, 0, 0, 0, 2'b11, 0, 0, 0, 0);
    // Reload overrides the same-cycle decrement.
    step(1, 1, 4, 3, 2'b00, 0, 0, 0, 0);
    idle(2);
    step(1, 1, 4, 3, 2'b00, 0, 0, 0, 0);
    idle(2);
    // Self-dependency reads the old count.
    step(1, 1, 6, 3, 2'b01, 6, 0, 0, 0);
    // Flush together with a valid issue drops it.
    idle(3);
    step(1, 1, 6, 3, 2'b00, 0, 0, 0, 1);
    step(1, 0, 0, 0, 2'b01, 6, 0, 0, 0);
    // Reset clears a pending entry.
    step(1, 1, 7, 6, 2'b00, 0, 0, 0, 0);
    drive_rst = 1'b1;
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    drive_rst = 1'b0;
    step(1, 0, 0, 0, 2'b01, 7, 0, 0, 0);

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 4) != 0), 1'($urandom), int'($urandom_range(0, 9)),
           int'($urandom_range(0, 7)), 2'($urandom), int'($urandom_range(0, 9)),
           int'($urandom_range(0, 9)), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 29) == 0));
    end
    idle(1);

    repeat (3) @(negedge clk);
    chk("queue_drained", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
